// File: rtl/hdma_req_splitter_pkg.sv
// Shared types for the host-DMA request splitter: request/response
// structs, bus widths and the splitter FSM state encoding.
package hdma_req_splitter_pkg;

    localparam int PADDR_BITS = 48;
    localparam int LEN_BITS   = 28;

    typedef struct packed {
        logic [PADDR_BITS-1:0] paddr;
        logic [LEN_BITS-1:0]   len;
        logic                  last;
    } dma_req_t;

    typedef struct packed {
        logic done;
    } dma_rsp_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } hdma_split_state_t;

    function automatic logic [LEN_BITS:0] min_len(input logic [LEN_BITS:0] a,
                                                  input logic [LEN_BITS:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/hdma_req_splitter_if.sv
// DMA request channel: valid/ready request handshake plus a completion
// pulse travelling in the opposite direction.
interface dmaIntf;
    import hdma_req_splitter_pkg::*;

    logic     valid;
    logic     ready;
    dma_req_t req;
    dma_rsp_t rsp;

    modport m (output valid, req, input ready, rsp);
    modport s (input valid, req, output ready, rsp);

endinterface

// File: rtl/hdma_req_splitter_done_queue.sv
// 1-bit in-order FIFO tracking issued chunks; each entry marks whether the
// chunk was the final one of its original request.
module hdma_done_queue #(
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic        gclk,
    input  logic        grst_n,
    input  logic        push,
    input  logic        din,
    input  logic        pop,
    output logic        dout,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push, do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/hdma_req_splitter.sv
// Splits host DMA requests into boundary-aligned XDMA chunks, limits the
// chunks in flight and merges chunk completions into one per request.
module hdma_req_splitter
    import hdma_req_splitter_pkg::*;
#(
    parameter int CHUNK_BITS    = 12,
    parameter int N_OUTSTANDING = 8
) (
    input  logic        aclk,
    input  logic        aresetn,
    dmaIntf.s           s_req,
    dmaIntf.m           m_req,
    output logic        busy,
    output logic        err_spurious,
    output logic [31:0] stat_chunks
);

    localparam int CW = $clog2(N_OUTSTANDING) + 1;
    localparam logic [LEN_BITS:0] CHUNK_MAX = (LEN_BITS+1)'(1) << CHUNK_BITS;

    hdma_split_state_t state_q, state_d;

    logic [PADDR_BITS-1:0] addr_q;
    logic [LEN_BITS-1:0]   rem_q;
    logic                  last_q;
    logic                  rdy_en_q;
    logic                  done_q;
    logic                  err_q;
    logic [31:0]           stat_q;

    logic [LEN_BITS:0]     to_bound, rem_ext, clen;
    logic                  is_final, accept, chunk_hs, credit_ok;
    logic                  q_dout, q_full, q_empty;
    logic [CW-1:0]         q_count;

    // Full 29-bit math: the distance to the boundary can be exactly 2^CHUNK_BITS.
    assign to_bound = CHUNK_MAX - (LEN_BITS+1)'(addr_q[CHUNK_BITS-1:0]);
    assign rem_ext  = {1'b0, rem_q};
    assign clen     = min_len(rem_ext, to_bound);
    assign is_final = (rem_ext == clen);

    // Credit is taken from the registered occupancy, so a pop never frees a
    // slot within the same cycle and valid never has to retract.
    assign credit_ok = ~q_full;

    assign s_req.ready = rdy_en_q & (state_q == ST_IDLE);
    assign s_req.rsp   = '{done: done_q};
    assign m_req.valid = (state_q == ST_ISSUE) & credit_ok;
    assign m_req.req   = '{paddr: addr_q,
                           len:   clen[LEN_BITS-1:0],
                           last:  last_q & is_final};

    assign accept   = s_req.valid & s_req.ready;
    assign chunk_hs = m_req.valid & m_req.ready;

    assign busy         = (state_q != ST_IDLE) | (q_count != '0);
    assign err_spurious = err_q;
    assign stat_chunks  = stat_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_ISSUE;
            ST_ISSUE: if (chunk_hs && is_final) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr_q   <= '0;
            rem_q    <= '0;
            last_q   <= 1'b0;
            rdy_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            stat_q   <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            if (accept) begin
                addr_q <= s_req.req.paddr;
                rem_q  <= s_req.req.len;
                last_q <= s_req.req.last;
            end else if (chunk_hs) begin
                addr_q <= addr_q + PADDR_BITS'(clen);
                rem_q  <= rem_q - clen[LEN_BITS-1:0];
            end
            done_q <= m_req.rsp.done & ~q_empty & q_dout;
            err_q  <= err_q | (m_req.rsp.done & q_empty);
            stat_q <= stat_q + 32'(chunk_hs);
        end
    end

    hdma_done_queue #(.DEPTH(N_OUTSTANDING)) u_done_q (
        .gclk   (aclk),
        .grst_n (aresetn),
        .push   (chunk_hs),
        .din    (is_final),
        .pop    (m_req.rsp.done),
        .dout   (q_dout),
        .full   (q_full),
        .empty  (q_empty),
        .count  (q_count)
    );

endmodule

// File: tb/tb_hdma_req_splitter.sv
// Directed bench for hdma_req_splitter: table of request/chunk vectors plus
// hand sequences for credit stall, push/pop overlap, spurious done and reset.
module tb_hdma_req_splitter;
    import hdma_req_splitter_pkg::*;

    logic        aclk;
    logic        aresetn;
    logic        busy, err_spurious;
    logic [31:0] stat_chunks;

    dmaIntf s_if();
    dmaIntf m_if();

    hdma_req_splitter #(.CHUNK_BITS(12), .N_OUTSTANDING(8)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_req        (s_if),
        .m_req        (m_if),
        .busy         (busy),
        .err_spurious (err_spurious),
        .stat_chunks  (stat_chunks)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int       n_cmp = 0;
    int       n_bad = 0;
    int       sdone_cnt = 0;
    dma_req_t ch_q[$];

    always @(posedge aclk) begin
        if (aresetn) begin
            if (m_if.valid && m_if.ready) ch_q.push_back(m_if.req);
            if (s_if.rsp.done) sdone_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [47:0]      paddr;
        logic [27:0]      len;
        logic             last;
        int               n;
        logic [2:0][47:0] ea;
        logic [2:0][27:0] el;
        logic [2:0]       ex;
    } vec_t;

    function automatic vec_t mk(input logic [47:0] pa, input logic [27:0] ln, input logic lst,
                                input int n,
                                input logic [47:0] a0, input logic [27:0] l0, input logic x0,
                                input logic [47:0] a1, input logic [27:0] l1, input logic x1,
                                input logic [47:0] a2, input logic [27:0] l2, input logic x2);
        vec_t v;
        v.paddr = pa; v.len = ln; v.last = lst; v.n = n;
        v.ea[0] = a0; v.el[0] = l0; v.ex[0] = x0;
        v.ea[1] = a1; v.el[1] = l1; v.ex[1] = x1;
        v.ea[2] = a2; v.el[2] = l2; v.ex[2] = x2;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge aclk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          t, base_d;
        logic [31:0] base_s;
        ch_q.delete();
        base_d = sdone_cnt;
        base_s = stat_chunks;
        m_if.ready = 1'b1;
        t = 0;
        while (!s_if.ready && t < 20) begin step; t++; end
        s_if.req   = '{paddr: v.paddr, len: v.len, last: v.last};
        s_if.valid = 1'b1;
        step;
        s_if.valid = 1'b0;
        chk($sformatf("v%0d_first_valid", idx), 64'(m_if.valid), 64'd1);
        chk($sformatf("v%0d_ready_low", idx), 64'(s_if.ready), 64'd0);
        t = 0;
        while (ch_q.size() < v.n && t < 64) begin step; t++; end
        chk($sformatf("v%0d_nchunks", idx), 64'(ch_q.size()), 64'(v.n));
        chk($sformatf("v%0d_ready_after", idx), 64'(s_if.ready), 64'd1);
        for (int i = 0; i < v.n && i < ch_q.size(); i++) begin
            chk($sformatf("v%0d_c%0d_paddr", idx, i), 64'(ch_q[i].paddr), 64'(v.ea[i]));
            chk($sformatf("v%0d_c%0d_len", idx, i), 64'(ch_q[i].len), 64'(v.el[i]));
            chk($sformatf("v%0d_c%0d_last", idx, i), 64'(ch_q[i].last), 64'(v.ex[i]));
        end
        chk($sformatf("v%0d_stat", idx), 64'(stat_chunks - base_s), 64'(v.n));
        for (int i = 0; i < v.n; i++) begin
            m_if.rsp.done = 1'b1;
            step;
            m_if.rsp.done = 1'b0;
            chk($sformatf("v%0d_sdone_%0d", idx, i), 64'(s_if.rsp.done), 64'(i == v.n - 1));
        end
        step;
        chk($sformatf("v%0d_sdone_pulse_end", idx), 64'(s_if.rsp.done), 64'd0);
        chk($sformatf("v%0d_sdone_count", idx), 64'(sdone_cnt - base_d), 64'd1);
        chk($sformatf("v%0d_idle", idx), 64'(busy), 64'd0);
    endtask

    vec_t vecs[5];

    initial begin
        int base_d, bad;

        vecs[0] = mk(48'h1000, 28'h3000, 1'b1, 3,
                     48'h1000, 28'h1000, 1'b0, 48'h2000, 28'h1000, 1'b0, 48'h3000, 28'h1000, 1'b1);
        vecs[1] = mk(48'h0FF0, 28'h20, 1'b1, 2,
                     48'h0FF0, 28'h10, 1'b0, 48'h1000, 28'h10, 1'b1, 48'h0, 28'h0, 1'b0);
        vecs[2] = mk(48'h5000, 28'h0, 1'b0, 1,
                     48'h5000, 28'h0, 1'b0, 48'h0, 28'h0, 1'b0, 48'h0, 28'h0, 1'b0);
        vecs[3] = mk(48'h2F00, 28'h1200, 1'b0, 3,
                     48'h2F00, 28'h100, 1'b0, 48'h3000, 28'h1000, 1'b0, 48'h4000, 28'h100, 1'b0);
        vecs[4] = mk(48'h7, 28'h5, 1'b1, 1,
                     48'h7, 28'h5, 1'b1, 48'h0, 28'h0, 1'b0, 48'h0, 28'h0, 1'b0);

        aresetn       = 1'b0;
        s_if.valid    = 1'b0;
        s_if.req      = '0;
        m_if.ready    = 1'b0;
        m_if.rsp.done = 1'b0;
        #12;
        chk("rst_s_ready", 64'(s_if.ready), 64'd0);
        chk("rst_m_valid", 64'(m_if.valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err_spurious), 64'd0);
        chk("rst_stat", 64'(stat_chunks), 64'd0);
        chk("rst_sdone", 64'(s_if.rsp.done), 64'd0);
        #10;
        aresetn = 1'b1;
        chk("rel_s_ready_pre_edge", 64'(s_if.ready), 64'd0);
        step;
        chk("rel_s_ready_rise", 64'(s_if.ready), 64'd1);

        for (int k = 0; k < 5; k++) run_vec(vecs[k], k);

        // Credit limit, full-queue pop, push/pop overlap at occupancy 4.
        ch_q.delete();
        base_d        = sdone_cnt;
        m_if.ready    = 1'b1;
        s_if.req      = '{paddr: 48'h0, len: 28'h10000, last: 1'b1};
        s_if.valid    = 1'b1;
        step;
        s_if.valid = 1'b0;
        repeat (20) step;
        chk("credit_stall_count", 64'(ch_q.size()), 64'd8);
        chk("credit_stall_valid", 64'(m_if.valid), 64'd0);
        chk("credit_stall_busy", 64'(busy), 64'd1);
        m_if.rsp.done = 1'b1;
        step;
        m_if.rsp.done = 1'b0;
        chk("full_pop_blocks", 64'(ch_q.size()), 64'd8);
        chk("full_pop_valid_next", 64'(m_if.valid), 64'd1);
        repeat (5) step;
        chk("one_more_count", 64'(ch_q.size()), 64'd9);
        chk("one_more_valid", 64'(m_if.valid), 64'd0);
        m_if.ready = 1'b0;
        repeat (4) begin
            m_if.rsp.done = 1'b1;
            step;
        end
        m_if.rsp.done = 1'b0;
        chk("occ4_valid", 64'(m_if.valid), 64'd1);
        m_if.ready    = 1'b1;
        m_if.rsp.done = 1'b1;
        step;
        m_if.rsp.done = 1'b0;
        m_if.ready    = 1'b0;
        chk("pushpop_count", 64'(ch_q.size()), 64'd10);
        step;
        m_if.ready = 1'b1;
        repeat (10) step;
        chk("pushpop_occ_kept", 64'(ch_q.size()), 64'd14);
        chk("pushpop_stall_valid", 64'(m_if.valid), 64'd0);
        chk("no_early_sdone", 64'(sdone_cnt - base_d), 64'd0);
        repeat (10) begin
            m_if.rsp.done = 1'b1;
            step;
        end
        m_if.rsp.done = 1'b0;
        repeat (3) step;
        chk("drain_count", 64'(ch_q.size()), 64'd16);
        chk("drain_sdone", 64'(sdone_cnt - base_d), 64'd1);
        chk("drain_err", 64'(err_spurious), 64'd0);
        chk("drain_busy", 64'(busy), 64'd0);
        bad = 0;
        for (int i = 0; i < ch_q.size(); i++)
            if (ch_q[i].paddr != 48'(i * 4096) || ch_q[i].len != 28'h1000 || ch_q[i].last != (i == 15))
                bad++;
        chk("credit_chunk_fields", 64'(bad), 64'd0);

        // Spurious completion, then async reset in the middle of ISSUE.
        m_if.rsp.done = 1'b1;
        step;
        m_if.rsp.done = 1'b0;
        chk("spurious_set", 64'(err_spurious), 64'd1);
        repeat (3) step;
        chk("spurious_sticky", 64'(err_spurious), 64'd1);
        m_if.ready = 1'b0;
        s_if.req   = '{paddr: 48'h1000, len: 28'h3000, last: 1'b1};
        s_if.valid = 1'b1;
        step;
        s_if.valid = 1'b0;
        chk("mid_issue_valid", 64'(m_if.valid), 64'd1);
        chk("mid_issue_busy", 64'(busy), 64'd1);
        #3;
        aresetn = 1'b0;
        #1;
        chk("async_rst_valid", 64'(m_if.valid), 64'd0);
        chk("async_rst_s_ready", 64'(s_if.ready), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_err", 64'(err_spurious), 64'd0);
        chk("async_rst_stat", 64'(stat_chunks), 64'd0);
        chk("async_rst_sdone", 64'(s_if.rsp.done), 64'd0);
        step;
        aresetn = 1'b1;
        step;
        chk("rerel_s_ready", 64'(s_if.ready), 64'd1);
        chk("rerel_valid", 64'(m_if.valid), 64'd0);
        m_if.rsp.done = 1'b1;
        step;
        m_if.rsp.done = 1'b0;
        chk("post_rst_spurious", 64'(err_spurious), 64'd1);
        chk("post_rst_busy", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hdma_req_splitter.md
# hdma_req_splitter

Host-DMA request splitter between the MMU host-DMA arbitration stage and the XDMA host channel. Consumes one arbitrated host DMA request per transaction and emits a sequence of XDMA-legal chunks that never exceed 2^CHUNK_BITS bytes and never cross a 2^CHUNK_BITS-aligned boundary. It limits outstanding chunks and collapses chunk completions back into one completion per original request. One instance is used per direction (read, write).

## Interface
- CHUNK_BITS, 12: log2 of maximum chunk size and boundary alignment (4 KB).
- N_OUTSTANDING, 8: maximum issued-but-not-done chunks; power of two, 2..32.
- aclk  in  1  clock.
- aresetn  in  1  reset; asynchronous, active-low.
- s_req  dmaIntf.s  upstream request, fields req.paddr[PADDR_BITS], req.len[LEN_BITS], req.last, handshake valid/ready, completion rsp.done (output here).
- m_req  dmaIntf.m  downstream XDMA chunk request; rsp.done is an input, one pulse per completed chunk.
- busy  out  1  high whenever FSM is not IDLE or any chunk is outstanding.
- err_spurious  out  1  sticky; set by m_req.rsp.done while no chunk is outstanding.
- stat_chunks  out  32  count of chunks issued (m_req valid&ready), wraps at 2^32.

## Operation
- FSM states: IDLE, ISSUE.
- IDLE: s_req.ready=1. On s_req valid&ready, latch addr=paddr, rem=len, last=req.last; go ISSUE.
- ISSUE: s_req.ready=0. Chunk length = min(rem, 2^CHUNK_BITS - addr[CHUNK_BITS-1:0]). Compute in LEN_BITS+1 width; no truncation.
- Chunk fields: paddr=addr, len=chunk length, last = last & (rem == chunk length).
- Issue is allowed only when outstanding count < N_OUTSTANDING.
- On m_req valid&ready: addr += chunk length, rem -= chunk length, push final flag (rem == chunk length) into done queue. If final, go IDLE.
- len=0 request: forwarded as exactly one chunk with len 0, final=1, last=req.last.
- Done queue: FIFO, depth N_OUTSTANDING, 1-bit entries. Outstanding count equals queue occupancy.
- m_req.rsp.done pops the queue. If popped entry is final, pulse s_req.rsp.done.
- m_req.rsp.done with empty queue: ignored, err_spurious set until reset.
- Simultaneous push and pop: both performed, occupancy unchanged; a full queue with a pop in the same cycle still blocks issue that cycle, since the credit check uses the registered count.
- A new request may be accepted while earlier chunks are outstanding. Completion order is in-order.

## Timing
- Reset (async assert, sync release): FSM=IDLE, m_req.valid=0, s_req.ready=0 while aresetn=0, s_req.rsp.done=0, queue empty, busy=0, err_spurious=0, stat_chunks=0.
- s_req.ready rises the first cycle after reset release.
- Accept in cycle N -> first chunk valid in N+1 (registered output).
- Chunks are back-to-back, one per cycle, while m_req.ready=1 and credits are available.
- m_req.valid, once high, holds with stable fields until ready. It never drops on credit loss; credits are checked before asserting valid.
- After the final chunk handshake in cycle N, s_req.ready=1 in N+1.
- s_req.rsp.done is registered: m_req.rsp.done for the final chunk in cycle N -> s_req.rsp.done in N+1, one-cycle pulse.
- Reset mid-operation discards the latched request and all outstanding state. Completions arriving after reset release with an empty queue set err_spurious.

## Structure
- The lynxTypes package provides PADDR_BITS, LEN_BITS and dma_req_t.
- Add a package enum for the FSM state (hdma_split_state_t).
- One sub-module: hdma_done_queue. This is a parameterised 1-bit FIFO with push, pop, full, empty and count outputs, using an async active-low reset.

## Test plan
- paddr=0x1000, len=0x3000, last=1 -> three chunks: (0x1000,0x1000,0), (0x2000,0x1000,0), (0x3000,0x1000,1). Three dones -> one s_req.rsp.done, one cycle after the third.
- paddr=0x0FF0, len=0x20, last=1 -> chunks (0x0FF0,0x10,0) and (0x1000,0x10,1). stat_chunks=2.
- len=0x10000 with m_req.ready=1 and no dones -> exactly 8 chunks issued, then valid stays low. One done -> exactly one more chunk issued.
- Push and pop in the same cycle at occupancy 4 -> occupancy stays 4. Completion order is preserved, so s_req.rsp.done fires only on the final-flag entry.
- m_req.rsp.done with the queue empty -> err_spurious=1 persists. Then assert aresetn=0 mid-ISSUE -> all outputs reach their reset values immediately, with no clock edge.
- len=0, last=0 -> one chunk (paddr, 0, last=0) is issued. Its done produces one s_req.rsp.done.
